// File: rtl/bullet_pool_if.sv
// Spawn handshake bundle for bullet_pool: requester (master) offers a bullet,
// the pool (slave) answers with ready and the slot it will fill.
interface bullet_pool_if #(
  parameter int N_SLOTS = 8,
  parameter int COORD_W = 8,
  parameter int COLOR_W = 3
);
  localparam int IDX_W = $clog2(N_SLOTS);

  logic               spawn_valid;
  logic               spawn_ready;
  logic [COORD_W-1:0] spawn_pos_x;
  logic [COORD_W-1:0] spawn_pos_y;
  logic [COORD_W-1:0] spawn_size_x;
  logic [COORD_W-1:0] spawn_size_y;
  logic [COLOR_W-1:0] spawn_color;
  logic [IDX_W-1:0]   spawn_slot;

  modport master (
    output spawn_valid, spawn_pos_x, spawn_pos_y, spawn_size_x, spawn_size_y, spawn_color,
    input  spawn_ready, spawn_slot
  );

  modport slave (
    input  spawn_valid, spawn_pos_x, spawn_pos_y, spawn_size_x, spawn_size_y, spawn_color,
    output spawn_ready, spawn_slot
  );
endinterface

// File: rtl/bullet_pool.sv
// Pool of N_SLOTS bullets: handshake spawn, strobed vertical motion, kill mask, two read ports.
// Optional: define BULLET_POOL_DESPAWN_EN to free bullets leaving the field instead of wrapping.
module bullet_pool #(
  parameter int N_SLOTS = 8,
  parameter int COORD_W = 8,
  parameter int COLOR_W = 3,
  parameter int STEP    = 5,
  parameter int Y_MAX   = 200,
  parameter int Y_WRAP  = 1,
  localparam int IDX_W  = $clog2(N_SLOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear,
  input  logic               tick,
  bullet_pool_if.slave       sp,
  input  logic [N_SLOTS-1:0] kill_mask,
  // One extra index bit so out-of-range requests are representable and read as zero.
  input  logic [IDX_W:0]     rd_idx_a,
  input  logic [IDX_W:0]     rd_idx_b,
  output logic [COORD_W-1:0] pos_x_a,
  output logic [COORD_W-1:0] pos_y_a,
  output logic [COORD_W-1:0] size_x_a,
  output logic [COORD_W-1:0] size_y_a,
  output logic [COLOR_W-1:0] color_a,
  output logic               alive_a,
  output logic [COORD_W-1:0] pos_x_b,
  output logic [COORD_W-1:0] pos_y_b,
  output logic [COORD_W-1:0] size_x_b,
  output logic [COORD_W-1:0] size_y_b,
  output logic [COLOR_W-1:0] color_b,
  output logic               alive_b,
  output logic [IDX_W:0]     active_count
);

  logic [COORD_W-1:0] pos_x  [N_SLOTS];
  logic [COORD_W-1:0] pos_y  [N_SLOTS];
  logic [COORD_W-1:0] size_x [N_SLOTS];
  logic [COORD_W-1:0] size_y [N_SLOTS];
  logic [COLOR_W-1:0] color  [N_SLOTS];
  logic [N_SLOTS-1:0] alive;

  logic [N_SLOTS-1:0] alive_nxt;
  logic [COORD_W-1:0] pos_y_nxt [N_SLOTS];
  logic [IDX_W:0]     count_nxt;
  logic [IDX_W-1:0]   free_idx;
  logic               any_free;
  logic               spawn_fire;

  // Lowest free slot wins; evaluated on the pre-edge state only.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!alive[i] && !any_free) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign sp.spawn_ready = rst_n & run & any_free & ~clear;
  assign sp.spawn_slot  = free_idx;
  assign spawn_fire     = sp.spawn_valid & sp.spawn_ready;

  // Per-slot precedence: clear > spawn > kill > tick.
  always_comb begin
    logic [COORD_W:0] sum;
    sum       = '0;
    alive_nxt = alive;
    pos_y_nxt = pos_y;
    if (run) begin
      if (clear) begin
        alive_nxt = '0;
      end else begin
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
          if (spawn_fire && free_idx == IDX_W'(i)) begin
            alive_nxt[i] = 1'b1;
            pos_y_nxt[i] = sp.spawn_pos_y;
          end else if (alive[i]) begin
            if (kill_mask[i]) begin
              alive_nxt[i] = 1'b0;
            end else if (tick) begin
              sum = {1'b0, pos_y[i]} + (COORD_W+1)'(STEP);
              if (sum >= (COORD_W+1)'(Y_MAX)) begin
`ifdef BULLET_POOL_DESPAWN_EN
                alive_nxt[i] = 1'b0;
`else
                pos_y_nxt[i] = COORD_W'(Y_WRAP);
`endif
              end else begin
                pos_y_nxt[i] = sum[COORD_W-1:0];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    count_nxt = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      count_nxt = count_nxt + (IDX_W+1)'(alive_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive        <= '0;
      active_count <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        pos_x[i]  <= '0;
        pos_y[i]  <= '0;
        size_x[i] <= '0;
        size_y[i] <= '0;
        color[i]  <= '0;
      end
    end else begin
      alive        <= alive_nxt;
      active_count <= count_nxt;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        pos_y[i] <= pos_y_nxt[i];
      end
      if (spawn_fire) begin
        pos_x[free_idx]  <= sp.spawn_pos_x;
        size_x[free_idx] <= sp.spawn_size_x;
        size_y[free_idx] <= sp.spawn_size_y;
        color[free_idx]  <= sp.spawn_color;
      end
    end
  end

  always_comb begin
    pos_x_a  = '0;
    pos_y_a  = '0;
    size_x_a = '0;
    size_y_a = '0;
    color_a  = '0;
    alive_a  = 1'b0;
    if (rd_idx_a < (IDX_W+1)'(N_SLOTS)) begin
      pos_x_a  = pos_x[rd_idx_a[IDX_W-1:0]];
      pos_y_a  = pos_y[rd_idx_a[IDX_W-1:0]];
      size_x_a = size_x[rd_idx_a[IDX_W-1:0]];
      size_y_a = size_y[rd_idx_a[IDX_W-1:0]];
      color_a  = color[rd_idx_a[IDX_W-1:0]];
      alive_a  = alive[rd_idx_a[IDX_W-1:0]];
    end
  end

  always_comb begin
    pos_x_b  = '0;
    pos_y_b  = '0;
    size_x_b = '0;
    size_y_b = '0;
    color_b  = '0;
    alive_b  = 1'b0;
    if (rd_idx_b < (IDX_W+1)'(N_SLOTS)) begin
      pos_x_b  = pos_x[rd_idx_b[IDX_W-1:0]];
      pos_y_b  = pos_y[rd_idx_b[IDX_W-1:0]];
      size_x_b = size_x[rd_idx_b[IDX_W-1:0]];
      size_y_b = size_y[rd_idx_b[IDX_W-1:0]];
      color_b  = color[rd_idx_b[IDX_W-1:0]];
      alive_b  = alive[rd_idx_b[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed vector bench for bullet_pool: table of per-cycle stimulus and expected
// post-edge outputs, plus hand sequences for out-of-range reads and async reset.
module tb_bullet_pool;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       clear;
  logic       tick;
  logic [7:0] kill_mask;
  logic [3:0] rd_idx_a;
  logic [3:0] rd_idx_b;
  logic [7:0] pos_x_a, pos_y_a, size_x_a, size_y_a;
  logic [2:0] color_a;
  logic       alive_a;
  logic [7:0] pos_x_b, pos_y_b, size_x_b, size_y_b;
  logic [2:0] color_b;
  logic       alive_b;
  logic [3:0] active_count;

  bullet_pool_if #(.N_SLOTS(8), .COORD_W(8), .COLOR_W(3)) sp ();

  bullet_pool #(
    .N_SLOTS(8), .COORD_W(8), .COLOR_W(3), .STEP(5), .Y_MAX(200), .Y_WRAP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .tick(tick),
    .sp(sp), .kill_mask(kill_mask), .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .pos_x_a(pos_x_a), .pos_y_a(pos_y_a), .size_x_a(size_x_a), .size_y_a(size_y_a),
    .color_a(color_a), .alive_a(alive_a),
    .pos_x_b(pos_x_b), .pos_y_b(pos_y_b), .size_x_b(size_x_b), .size_y_b(size_y_b),
    .color_b(color_b), .alive_b(alive_b),
    .active_count(active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       run, clr, tick, sv;
    logic [7:0] px, py, sx;
    logic [2:0] col;
    logic [7:0] kill;
    logic [3:0] ra, rb;
    logic       rdy, cs;
    logic [2:0] slot;
    logic [3:0] cnt;
    logic [7:0] ay, ax, asx;
    logic [2:0] acol;
    logic       aa, ab;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input int run_i, clr_i, tick_i, sv_i, px_i, py_i, sx_i, col_i, kill_i,
                     ra_i, rb_i, rdy_i, cs_i, slot_i, cnt_i, ay_i, ax_i, asx_i, acol_i,
                     aa_i, ab_i);
    vec_t v;
    v.run = 1'(run_i);  v.clr = 1'(clr_i);  v.tick = 1'(tick_i); v.sv = 1'(sv_i);
    v.px = 8'(px_i);    v.py = 8'(py_i);    v.sx = 8'(sx_i);     v.col = 3'(col_i);
    v.kill = 8'(kill_i); v.ra = 4'(ra_i);   v.rb = 4'(rb_i);
    v.rdy = 1'(rdy_i);  v.cs = 1'(cs_i);    v.slot = 3'(slot_i); v.cnt = 4'(cnt_i);
    v.ay = 8'(ay_i);    v.ax = 8'(ax_i);    v.asx = 8'(asx_i);   v.acol = 3'(acol_i);
    v.aa = 1'(aa_i);    v.ab = 1'(ab_i);
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    run = v.run; clear = v.clr; tick = v.tick; kill_mask = v.kill;
    rd_idx_a = v.ra; rd_idx_b = v.rb;
    sp.spawn_valid = v.sv; sp.spawn_pos_x = v.px; sp.spawn_pos_y = v.py;
    sp.spawn_size_x = v.sx; sp.spawn_size_y = v.sx; sp.spawn_color = v.col;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; clear = 1'b0; tick = 1'b0; kill_mask = '0;
    rd_idx_a = '0; rd_idx_b = '0;
    sp.spawn_valid = 1'b0; sp.spawn_pos_x = '0; sp.spawn_pos_y = '0;
    sp.spawn_size_x = '0; sp.spawn_size_y = '0; sp.spawn_color = '0;

    // run,clr,tick,sv, px,py,sx,col,kill, ra,rb, rdy,cs,slot,cnt, ay,ax,asx,acol,aa, ab
    add(1,0,0,1, 160,19,16,1,0,  0,0, 1,1,1,1, 19,160,16,1,1, 1);
    add(1,0,0,1, 10,195,4,2,0,   1,0, 1,1,2,2, 195,10,4,2,1, 1);
`ifdef BULLET_POOL_DESPAWN_EN
    add(1,0,1,0, 0,0,0,0,0,      0,1, 1,1,1,1, 24,160,16,1,1, 0);
`else
    add(1,0,1,0, 0,0,0,0,0,      1,1, 1,1,2,2, 1,10,4,2,1, 1);
`endif
    add(1,1,1,1, 70,70,3,3,0,    0,1, 0,0,0,0, 24,160,16,1,0, 0);
    for (int k = 0; k < 8; k++)
      add(1,0,0,1, 20+k,50+k,8,1,0, k,k, (k<7)?1:0,(k<7)?1:0,(k+1)%8,k+1, 50+k,20+k,8,1,1, 1);
    add(1,0,0,1, 99,99,9,5,0,    0,0, 0,0,0,8, 50,20,8,1,1, 1);
    add(1,0,0,0, 0,0,0,0,8'h04,  2,2, 1,1,2,7, 52,22,8,1,0, 0);
    add(1,0,0,1, 77,88,8,2,0,    2,2, 0,0,0,8, 88,77,8,2,1, 1);
    add(1,0,0,0, 0,0,0,0,8'h08,  3,3, 1,1,3,7, 53,23,8,1,0, 0);
    add(1,0,1,1, 33,44,6,4,8'h01, 3,0, 1,1,0,7, 44,33,6,4,1, 0);
    add(1,0,0,0, 0,0,0,0,0,      1,4, 1,1,0,7, 56,21,8,1,1, 1);
    add(1,0,0,0, 0,0,0,0,0,      2,7, 1,1,0,7, 93,77,8,2,1, 1);
    add(1,0,0,0, 0,0,0,0,0,      7,0, 1,1,0,7, 62,27,8,1,1, 0);
    add(0,0,1,1, 5,5,5,5,8'hFF,  1,0, 0,0,0,7, 56,21,8,1,1, 0);
    add(1,1,1,1, 5,5,5,5,0,      1,3, 0,0,0,0, 56,21,8,1,0, 0);
    add(1,0,0,0, 0,0,0,0,0,      3,3, 1,1,0,0, 44,33,6,4,0, 0);
    add(1,0,0,1, 9,9,2,1,0,      0,0, 1,1,1,1, 9,9,2,1,1, 1);
    add(1,0,0,1, 11,12,3,2,0,    1,1, 1,1,2,2, 12,11,3,2,1, 1);

    #12;
    chk("reset spawn_ready", -1, 32'(sp.spawn_ready), 0);
    chk("reset spawn_slot", -1, 32'(sp.spawn_slot), 0);
    chk("reset active_count", -1, 32'(active_count), 0);
    chk("reset alive_a", -1, 32'(alive_a), 0);
    chk("reset pos_x_a", -1, 32'(pos_x_a), 0);
    chk("reset pos_y_a", -1, 32'(pos_y_a), 0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i]);
      @(posedge clk);
      #1;
      chk("spawn_ready", i, 32'(sp.spawn_ready), 32'(tv[i].rdy));
      if (tv[i].cs) chk("spawn_slot", i, 32'(sp.spawn_slot), 32'(tv[i].slot));
      chk("active_count", i, 32'(active_count), 32'(tv[i].cnt));
      chk("pos_y_a", i, 32'(pos_y_a), 32'(tv[i].ay));
      chk("pos_x_a", i, 32'(pos_x_a), 32'(tv[i].ax));
      chk("size_x_a", i, 32'(size_x_a), 32'(tv[i].asx));
      chk("size_y_a", i, 32'(size_y_a), 32'(tv[i].asx));
      chk("color_a", i, 32'(color_a), 32'(tv[i].acol));
      chk("alive_a", i, 32'(alive_a), 32'(tv[i].aa));
      chk("alive_b", i, 32'(alive_b), 32'(tv[i].ab));
    end

    // Out-of-range read indices; slots 0 and 1 are alive here.
    sp.spawn_valid = 1'b0;
    rd_idx_a = 4'd8;
    rd_idx_b = 4'd9;
    #1;
    chk("oor pos_x_b", 100, 32'(pos_x_b), 0);
    chk("oor pos_y_b", 100, 32'(pos_y_b), 0);
    chk("oor size_x_b", 100, 32'(size_x_b), 0);
    chk("oor size_y_b", 100, 32'(size_y_b), 0);
    chk("oor color_b", 100, 32'(color_b), 0);
    chk("oor alive_b", 100, 32'(alive_b), 0);
    chk("oor alive_a", 100, 32'(alive_a), 0);
    chk("oor pos_x_a", 100, 32'(pos_x_a), 0);

    // Async reset in the middle of a tick cycle, checked before the next edge.
    rd_idx_a = 4'd1;
    rd_idx_b = 4'd0;
    tick = 1'b1;
    #1;
    chk("pre-reset alive_a", 101, 32'(alive_a), 1);
    rst_n = 1'b0;
    #1;
    chk("async active_count", 101, 32'(active_count), 0);
    chk("async alive_a", 101, 32'(alive_a), 0);
    chk("async pos_y_a", 101, 32'(pos_y_a), 0);
    chk("async pos_x_a", 101, 32'(pos_x_a), 0);
    chk("async alive_b", 101, 32'(alive_b), 0);
    chk("async spawn_ready", 101, 32'(sp.spawn_ready), 0);
    chk("async spawn_slot", 101, 32'(sp.spawn_slot), 0);

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
